// File: rtl/command_word_write_sequencer.sv
// command_word_write_sequencer
// Samples the CPU write cycle, detects the rising edge of the write strobe,
// classifies the written byte as ICW1..ICW4 or OCW1..OCW3, and drives it onto
// the internal data bus with one single-cycle strobe for the matching register.
module command_word_write_sequencer (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       chip_select_n,
  input  logic       write_enable_n,
  input  logic       address,
  input  logic [7:0] data_bus_in,
  output logic [7:0] internal_data_bus,
  output logic       write_initial_command_word_1,
  output logic       write_initial_command_word_2,
  output logic       write_initial_command_word_3,
  output logic       write_initial_command_word_4,
  output logic       write_operation_control_word_1,
  output logic       write_operation_control_word_2,
  output logic       write_operation_control_word_3,
  output logic       initialization_in_progress,
  output logic       end_of_initialization
);

  typedef enum logic [2:0] {
    UNINIT    = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } state_t;

  state_t     state;
  state_t     next_state;

  logic       we_q;
  logic       cs_q;
  logic       address_q;
  logic [7:0] data_q;
  logic       write_done;

  logic       cascade_mode;
  logic       icw4_needed;
  logic       latch_flags;
  logic       load_bus;

  logic       icw1_next;
  logic       icw2_next;
  logic       icw3_next;
  logic       icw4_next;
  logic       ocw1_next;
  logic       ocw2_next;
  logic       ocw3_next;
  logic       eoi_next;
  logic       in_wait_state;

  // Hold the bus values of the last low cycle of the write strobe.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      we_q      <= 1'b1;
      cs_q      <= 1'b1;
      address_q <= 1'b0;
      data_q    <= 8'h00;
    end else begin
      we_q <= write_enable_n;
      if (!write_enable_n) begin
        cs_q      <= chip_select_n;
        address_q <= address;
        data_q    <= data_bus_in;
      end
    end
  end

  // A write ends on the low-to-high edge of the strobe; deselected writes never count.
  assign write_done = ~we_q & write_enable_n & ~cs_q;

  assign in_wait_state = (state == WAIT_ICW2) || (state == WAIT_ICW3) ||
                         (state == WAIT_ICW4);

  // Decode the completed write against the current sequencing state.
  always_comb begin
    next_state  = state;
    icw1_next   = 1'b0;
    icw2_next   = 1'b0;
    icw3_next   = 1'b0;
    icw4_next   = 1'b0;
    ocw1_next   = 1'b0;
    ocw2_next   = 1'b0;
    ocw3_next   = 1'b0;
    latch_flags = 1'b0;
    load_bus    = 1'b0;
    eoi_next    = 1'b0;

    if (write_done) begin
      if (!address_q && data_q[4]) begin
        // ICW1 is always honoured and restarts whatever sequence was running.
        icw1_next   = 1'b1;
        latch_flags = 1'b1;
        load_bus    = 1'b1;
        next_state  = WAIT_ICW2;
      end else begin
        case (state)
          WAIT_ICW2: begin
            if (address_q) begin
              icw2_next = 1'b1;
              load_bus  = 1'b1;
              if (cascade_mode)
                next_state = WAIT_ICW3;
              else if (icw4_needed)
                next_state = WAIT_ICW4;
              else
                next_state = READY;
            end
          end
          WAIT_ICW3: begin
            if (address_q) begin
              icw3_next  = 1'b1;
              load_bus   = 1'b1;
              next_state = icw4_needed ? WAIT_ICW4 : READY;
            end
          end
          WAIT_ICW4: begin
            if (address_q) begin
              icw4_next  = 1'b1;
              load_bus   = 1'b1;
              next_state = READY;
            end
          end
          READY: begin
            load_bus = 1'b1;
            if (address_q)
              ocw1_next = 1'b1;
            else if (data_q[3])
              ocw3_next = 1'b1;
            else
              ocw2_next = 1'b1;
          end
          default: begin
            next_state = state;
          end
        endcase
      end
    end

    eoi_next = in_wait_state && (next_state == READY);
  end

  // Sequencing state register.
  always_ff @(posedge clock) begin
    if (!reset_n)
      state <= UNINIT;
    else
      state <= next_state;
  end

  // Mode flags taken from ICW1: SNGL=0 means cascade, IC4 requests ICW4.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cascade_mode <= 1'b0;
      icw4_needed  <= 1'b0;
    end else if (latch_flags) begin
      cascade_mode <= ~data_q[1];
      icw4_needed  <= data_q[0];
    end
  end

  // Registered strobes, end-of-init pulse and the internal data bus.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      internal_data_bus              <= 8'h00;
      write_initial_command_word_1   <= 1'b0;
      write_initial_command_word_2   <= 1'b0;
      write_initial_command_word_3   <= 1'b0;
      write_initial_command_word_4   <= 1'b0;
      write_operation_control_word_1 <= 1'b0;
      write_operation_control_word_2 <= 1'b0;
      write_operation_control_word_3 <= 1'b0;
      end_of_initialization          <= 1'b0;
    end else begin
      if (load_bus)
        internal_data_bus <= data_q;
      write_initial_command_word_1   <= icw1_next;
      write_initial_command_word_2   <= icw2_next;
      write_initial_command_word_3   <= icw3_next;
      write_initial_command_word_4   <= icw4_next;
      write_operation_control_word_1 <= ocw1_next;
      write_operation_control_word_2 <= ocw2_next;
      write_operation_control_word_3 <= ocw3_next;
      end_of_initialization          <= eoi_next;
    end
  end

  assign initialization_in_progress = in_wait_state;

endmodule

// File: tb/tb_command_word_write_sequencer.sv
// Testbench for command_word_write_sequencer: directed write cycles, a
// queue-based model of the initialization sequence checked every cycle, and
// literal expectations after each write.
module tb_command_word_write_sequencer;

  logic       clock;
  logic       reset_n;
  logic       chip_select_n;
  logic       write_enable_n;
  logic       address;
  logic [7:0] data_bus_in;
  logic [7:0] internal_data_bus;
  logic       icw1, icw2, icw3, icw4;
  logic       ocw1, ocw2, ocw3;
  logic       init_in_progress;
  logic       end_of_init;

  int checks = 0;
  int errors = 0;
  bit check_en = 0;

  localparam logic [6:0] S_NONE = 7'b0000000;
  localparam logic [6:0] S_ICW1 = 7'b0000001;
  localparam logic [6:0] S_ICW2 = 7'b0000010;
  localparam logic [6:0] S_ICW3 = 7'b0000100;
  localparam logic [6:0] S_ICW4 = 7'b0001000;
  localparam logic [6:0] S_OCW1 = 7'b0010000;
  localparam logic [6:0] S_OCW2 = 7'b0100000;
  localparam logic [6:0] S_OCW3 = 7'b1000000;

  wire [6:0] dut_strobes = {ocw3, ocw2, ocw1, icw4, icw3, icw2, icw1};

  command_word_write_sequencer dut (
    .clock                          (clock),
    .reset_n                        (reset_n),
    .chip_select_n                  (chip_select_n),
    .write_enable_n                 (write_enable_n),
    .address                        (address),
    .data_bus_in                    (data_bus_in),
    .internal_data_bus              (internal_data_bus),
    .write_initial_command_word_1   (icw1),
    .write_initial_command_word_2   (icw2),
    .write_initial_command_word_3   (icw3),
    .write_initial_command_word_4   (icw4),
    .write_operation_control_word_1 (ocw1),
    .write_operation_control_word_2 (ocw2),
    .write_operation_control_word_3 (ocw3),
    .initialization_in_progress     (init_in_progress),
    .end_of_initialization          (end_of_init)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Behavioural model: a list of ICW numbers still owed after ICW1.
  int         m_pending[$];
  bit         m_started;
  bit         m_prev_low;
  bit         m_cs;
  bit         m_a;
  logic [7:0] m_d;
  logic [6:0] exp_strobes;
  logic [7:0] exp_bus;
  bit         exp_iip;
  bit         exp_eoi;

  // Model update on each rising edge from the sampled bus.
  always @(posedge clock) begin
    int n;
    exp_strobes = S_NONE;
    exp_eoi     = 1'b0;
    if (!reset_n) begin
      m_pending.delete();
      m_started  = 1'b0;
      m_prev_low = 1'b0;
      m_cs       = 1'b1;
      exp_bus    = 8'h00;
    end else begin
      if (m_prev_low && write_enable_n && !m_cs) begin
        if (!m_a && m_d[4]) begin
          exp_strobes = S_ICW1;
          exp_bus     = m_d;
          m_pending.delete();
          m_pending.push_back(2);
          if (!m_d[1]) m_pending.push_back(3);
          if (m_d[0])  m_pending.push_back(4);
          m_started = 1'b1;
        end else if (m_pending.size() > 0) begin
          if (m_a) begin
            n = m_pending.pop_front();
            exp_strobes = 7'(1 << (n - 1));
            exp_bus     = m_d;
            if (m_pending.size() == 0) exp_eoi = 1'b1;
          end
        end else if (m_started) begin
          exp_bus = m_d;
          if (m_a)         exp_strobes = S_OCW1;
          else if (m_d[3]) exp_strobes = S_OCW3;
          else             exp_strobes = S_OCW2;
        end
      end
      if (!write_enable_n) begin
        m_cs = chip_select_n;
        m_a  = address;
        m_d  = data_bus_in;
      end
      m_prev_low = !write_enable_n;
    end
    exp_iip = (m_pending.size() > 0);
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clock) begin
    if (check_en) begin
      checks++;
      if (dut_strobes !== exp_strobes) begin
        errors++;
        $display("[TB] FAIL model_strobes t=%0t got %b want %b", $time, dut_strobes, exp_strobes);
      end
      checks++;
      if (internal_data_bus !== exp_bus) begin
        errors++;
        $display("[TB] FAIL model_bus t=%0t got %h want %h", $time, internal_data_bus, exp_bus);
      end
      checks++;
      if (init_in_progress !== exp_iip) begin
        errors++;
        $display("[TB] FAIL model_iip t=%0t got %b want %b", $time, init_in_progress, exp_iip);
      end
      checks++;
      if (end_of_init !== exp_eoi) begin
        errors++;
        $display("[TB] FAIL model_eoi t=%0t got %b want %b", $time, end_of_init, exp_eoi);
      end
    end
  end

  // One full write cycle; returns at the falling edge after the strobe edge.
  task automatic applyStimulus(input logic cs_n, input logic a, input logic [7:0] d);
    @(negedge clock);
    chip_select_n  = cs_n;
    address        = a;
    data_bus_in    = d;
    write_enable_n = 1'b0;
    @(negedge clock);
    write_enable_n = 1'b1;
    @(posedge clock);
    @(negedge clock);
  endtask

  // Literal comparison of the DUT outputs.
  task automatic checkOutput(input string name, input logic [6:0] s, input logic [7:0] b,
                             input logic iip, input logic eoi);
    checks++;
    if (dut_strobes !== s) begin
      errors++;
      $display("[TB] FAIL %s strobes got %b want %b", name, dut_strobes, s);
    end
    checks++;
    if (internal_data_bus !== b) begin
      errors++;
      $display("[TB] FAIL %s bus got %h want %h", name, internal_data_bus, b);
    end
    checks++;
    if (init_in_progress !== iip) begin
      errors++;
      $display("[TB] FAIL %s iip got %b want %b", name, init_in_progress, iip);
    end
    checks++;
    if (end_of_init !== eoi) begin
      errors++;
      $display("[TB] FAIL %s eoi got %b want %b", name, end_of_init, eoi);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  // Directed sequence.
  initial begin
    reset_n        = 1'b0;
    chip_select_n  = 1'b1;
    write_enable_n = 1'b1;
    address        = 1'b0;
    data_bus_in    = 8'h00;
    repeat (3) @(negedge clock);
    check_en = 1'b1;
    checkOutput("reset", S_NONE, 8'h00, 1'b0, 1'b0);
    reset_n = 1'b1;

    // Single mode with ICW4.
    applyStimulus(1'b0, 1'b0, 8'h13); checkOutput("single_icw1", S_ICW1, 8'h13, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h20); checkOutput("single_icw2", S_ICW2, 8'h20, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h01); checkOutput("single_icw4", S_ICW4, 8'h01, 1'b0, 1'b1);
    @(negedge clock);                 checkOutput("single_after", S_NONE, 8'h01, 1'b0, 1'b0);

    // Cascade without ICW4.
    applyStimulus(1'b0, 1'b0, 8'h10); checkOutput("casc_icw1", S_ICW1, 8'h10, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h08); checkOutput("casc_icw2", S_ICW2, 8'h08, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h04); checkOutput("casc_icw3", S_ICW3, 8'h04, 1'b0, 1'b1);

    // Operation control words in READY.
    applyStimulus(1'b0, 1'b1, 8'hFE); checkOutput("ocw1", S_OCW1, 8'hFE, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h20); checkOutput("ocw2", S_OCW2, 8'h20, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h0B); checkOutput("ocw3", S_OCW3, 8'h0B, 1'b0, 1'b0);

    // Ignored writes while waiting for ICW2.
    applyStimulus(1'b0, 1'b0, 8'h10); checkOutput("ign_icw1", S_ICW1, 8'h10, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h20); checkOutput("ign_ocw_in_wait", S_NONE, 8'h10, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h55); checkOutput("ign_cs_high", S_NONE, 8'h10, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h08); checkOutput("ign_then_icw2", S_ICW2, 8'h08, 1'b1, 1'b0);

    // Restart mid-sequence with new flags.
    applyStimulus(1'b0, 1'b0, 8'h11); checkOutput("rs_icw1", S_ICW1, 8'h11, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h40); checkOutput("rs_icw2", S_ICW2, 8'h40, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h17); checkOutput("rs_new_icw1", S_ICW1, 8'h17, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h21); checkOutput("rs_new_icw2", S_ICW2, 8'h21, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h03); checkOutput("rs_new_icw4", S_ICW4, 8'h03, 1'b0, 1'b1);

    // Reset in WAIT_ICW3 on the same edge a write completes.
    applyStimulus(1'b0, 1'b0, 8'h10); checkOutput("rst_icw1", S_ICW1, 8'h10, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h08); checkOutput("rst_icw2", S_ICW2, 8'h08, 1'b1, 1'b0);
    @(negedge clock);
    chip_select_n  = 1'b0;
    address        = 1'b1;
    data_bus_in    = 8'h04;
    write_enable_n = 1'b0;
    @(negedge clock);
    write_enable_n = 1'b1;
    reset_n        = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checkOutput("rst_collide", S_NONE, 8'h00, 1'b0, 1'b0);
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 8'h99); checkOutput("rst_then_a1", S_NONE, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clock);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
